seg_message_scroller: RTL
=========================

# seg_message_scroller

Parametrised scrolling-message engine for the seven-segment bank. A message of up to MSG_MAX glyphs is held in an internal buffer and shifted across NUM_DIGITS displays, one position per shift event. Shift events come from an internal prescaler or a manual step pulse. The engine supports left/right direction, pause, and looped or one-shot playback, and sits between the switch/key front end and the HEX outputs.

## Interface
- NUM_DIGITS, 8, number of seven-segment digits driven.
- MSG_MAX, 16, message buffer depth in glyphs (power of two, ≥2); AW = $clog2(MSG_MAX).
- TICK_DIV, 25_000_000, CLOCK_50 cycles per automatic shift; 0 disables automatic shifting (step only).
- GAP, 3, blank glyphs inserted between repetitions in loop mode.

Ports:
- CLOCK_50  in  1  sole clock, all logic on rising edge.
- reset  in  1  synchronous, active-high.
- wr_en  in  1  write wr_data into buffer[wr_addr] this cycle.
- wr_addr  in  AW  buffer write address.
- wr_data  in  7  glyph, active-low, bit6=a … bit0=g.
- msg_len  in  AW+1  message length; sampled on start; values >MSG_MAX clamp to MSG_MAX.
- start  in  1  pulse: (re)start playback.
- pause  in  1  level: suppress shift events and freeze prescaler.
- step  in  1  pulse: manual shift event.
- dir  in  1  0: new glyph enters digit 0 and moves toward digit N-1; 1: new glyph enters digit N-1 and moves toward digit 0.
- loop  in  1  1: repeat forever; 0: one-shot.
- hex  out  7*NUM_DIGITS  digit k at [7k+6:7k], active-low.
- pos  out  AW  buffer index of the next glyph to be fetched.
- busy  out  1  high in SCROLL or DRAIN.
- done  out  1  high in DONE.

## Operation
- BLANK = 7'h7F.
- States:
  - IDLE: reset state.
  - SCROLL: glyphs 0..len-1 are fed in.
  - DRAIN: blanks are fed in.
  - DONE.
- start (any state): clear display to BLANK, pos=0, prescaler=0, latch len. If len=0, go to DONE; otherwise go to SCROLL.
- Shift event: adv = (tick | step) & ~pause & busy. tick and step in the same cycle count as one shift.
- On adv, every digit takes its neighbour's value per dir, and the entry digit takes the fed glyph.
- SCROLL: feed buffer[pos] and increment pos. After feeding glyph len-1, go to DRAIN with a drain count of 0.
- DRAIN: feed BLANK and increment the drain count.
  - loop=1: after GAP blanks, pos=0 and return to SCROLL; GAP=0 returns immediately.
  - loop=0: after NUM_DIGITS blanks, go to DONE. The display is then fully blank.
- loop is sampled at each DRAIN decision; dir is sampled at each adv. Changes take effect on the next shift.
- Writes are accepted in every state. A write to the address being fetched in the same cycle feeds the old value; the new value is used on the next fetch.
- DONE holds the display until start or reset.

## Timing
- reset: state IDLE, hex all BLANK, pos=0, busy=0, done=0, prescaler=0, every buffer entry BLANK. reset overrides start, step and wr_en.
- start at cycle t: from t+1, busy=1, hex all BLANK, pos=0.
- adv at cycle t: hex, pos and state update at t+1 (one-cycle latency).
- tick asserts for one cycle every TICK_DIV unpaused busy cycles. The prescaler holds while pause is high and resumes from its held value.
- start during SCROLL or DRAIN: restart per Operation; no shift happens in that cycle.
- wr_addr ≥ msg_len is legal and stored.

## Structure
- Shared package seg_pkg holds:
  - BLANK constant.
  - Glyph constants for digits 0–9 plus H, E, L, O, P in the same active-low encoding.
  - State enum (IDLE, SCROLL, DRAIN, DONE).
- Sub-module seg_tick_gen: parametrised prescaler with clear and hold inputs, producing the tick pulse.
- Buffer: register array, written synchronously and read combinationally.

## Test plan
Settings: NUM_DIGITS=8, MSG_MAX=16, TICK_DIV=4, GAP=3. Glyphs: H=7'b1001000, E=7'b0110000, L=7'b1110001, O=7'b0000001.
- Reset mid-scroll -> next cycle hex all 7F, busy=0, pos=0; a step pulse has no effect.
- Load HELLO, len=5, dir=0, loop=1, start, 8 steps -> digits 7..0 = H,E,L,L,O,blank,blank,blank; step 9 -> digit 0 = H.
- Same load, loop=0, step only -> DONE after 13 steps, hex all 7F, done=1, busy=0.
- dir=1, one step -> digit 7 = H, all others 7F.
- Automatic ticks with pause high for 10 cycles in the middle -> shift interval is exactly 4 unpaused cycles; tick plus simultaneous step gives a single shift.
- len=0 start -> done=1 at t+1, hex all 7F; len=20 -> behaves as len=16 (pos wraps from 15 to DRAIN).

Source files
------------

// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment bank: active-low glyphs (bit6=a .. bit0=g)
// and the scroller state encoding.
package seg_pkg;

  localparam logic [6:0] BLANK   = 7'h7F;

  localparam logic [6:0] GLYPH_0 = 7'b0000001;
  localparam logic [6:0] GLYPH_1 = 7'b1001111;
  localparam logic [6:0] GLYPH_2 = 7'b0010010;
  localparam logic [6:0] GLYPH_3 = 7'b0000110;
  localparam logic [6:0] GLYPH_4 = 7'b1001100;
  localparam logic [6:0] GLYPH_5 = 7'b0100100;
  localparam logic [6:0] GLYPH_6 = 7'b0100000;
  localparam logic [6:0] GLYPH_7 = 7'b0001111;
  localparam logic [6:0] GLYPH_8 = 7'b0000000;
  localparam logic [6:0] GLYPH_9 = 7'b0000100;
  localparam logic [6:0] GLYPH_H = 7'b1001000;
  localparam logic [6:0] GLYPH_E = 7'b0110000;
  localparam logic [6:0] GLYPH_L = 7'b1110001;
  localparam logic [6:0] GLYPH_O = 7'b0000001;
  localparam logic [6:0] GLYPH_P = 7'b0011000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCROLL,
    ST_DRAIN,
    ST_DONE
  } state_t;

endpackage

// File: rtl/seg_tick_gen.sv
// Shift prescaler: down-counter reloaded with DIV-1, pulses tick on terminal count.
// clear restarts the period, hold freezes the count, run gates counting entirely.
// DIV = 0 never ticks.
module seg_tick_gen #(
  parameter int DIV = 25_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic hold,
  input  logic run,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] RELOAD = CW'((DIV > 0) ? DIV - 1 : 0);
  localparam logic ENABLED = (DIV > 0);

  logic [CW-1:0] cnt_q;
  logic          counting;

  assign counting = run & ~hold & ~clear;
  assign tick     = ENABLED & counting & (cnt_q == '0);

  // count down while running and not held; reload on terminal count or clear
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt_q <= RELOAD;
    end else if (counting) begin
      if (cnt_q == '0) cnt_q <= RELOAD;
      else             cnt_q <= cnt_q - CW'(1);
    end
  end

endmodule

// File: rtl/seg_message_scroller.sv
// Scrolling-message engine: shifts a buffered message across NUM_DIGITS
// seven-segment digits on prescaler ticks or manual steps.
//
// state     | meaning
// ----------+---------------------------------------------------------
// ST_IDLE   | after reset, display blank, waiting for start
// ST_SCROLL | feeding buffer[pos] into the entry digit on each shift
// ST_DRAIN  | feeding blanks (GAP in loop mode, NUM_DIGITS in one-shot)
// ST_DONE   | one-shot finished, display held blank until start
module seg_message_scroller
  import seg_pkg::*;
#(
  parameter  int NUM_DIGITS = 8,
  parameter  int MSG_MAX    = 16,
  parameter  int TICK_DIV   = 25_000_000,
  parameter  int GAP        = 3,
  localparam int AW         = $clog2(MSG_MAX)
) (
  input  logic                    CLOCK_50,
  input  logic                    reset,
  input  logic                    wr_en,
  input  logic [AW-1:0]           wr_addr,
  input  logic [6:0]              wr_data,
  input  logic [AW:0]             msg_len,
  input  logic                    start,
  input  logic                    pause,
  input  logic                    step,
  input  logic                    dir,
  input  logic                    loop,
  output logic [7*NUM_DIGITS-1:0] hex,
  output logic [AW-1:0]           pos,
  output logic                    busy,
  output logic                    done
);

  localparam int DMAX = (GAP > NUM_DIGITS) ? GAP : NUM_DIGITS;
  localparam int DW   = $clog2(DMAX + 1);
  localparam logic [AW:0] LEN_MAX  = (AW + 1)'(MSG_MAX);
  localparam logic [AW:0] LEN_ONE  = (AW + 1)'(1);
  localparam logic [DW-1:0] GAP_N  = DW'(GAP);
  localparam logic [DW-1:0] DRAIN_N = DW'(NUM_DIGITS);

  state_t        state_q, state_d;
  logic [6:0]    msg_buf [MSG_MAX];
  logic [6:0]    disp_q  [NUM_DIGITS];
  logic [6:0]    disp_d  [NUM_DIGITS];
  logic [AW-1:0] pos_q, pos_d;
  logic [AW:0]   len_q, len_d, len_in;
  logic [DW-1:0] drain_q, drain_d, drain_inc;
  logic          tick, adv, shift, clr;
  logic [6:0]    feed;

  assign busy      = (state_q == ST_SCROLL) || (state_q == ST_DRAIN);
  assign done      = (state_q == ST_DONE);
  assign pos       = pos_q;
  assign adv       = (tick | step) & ~pause & busy;
  assign len_in    = (msg_len > LEN_MAX) ? LEN_MAX : msg_len;
  assign drain_inc = drain_q + DW'(1);

  seg_tick_gen #(.DIV(TICK_DIV)) u_tick (
    .clk   (CLOCK_50),
    .reset (reset),
    .clear (start),
    .hold  (pause),
    .run   (busy),
    .tick  (tick)
  );

  // message buffer: synchronous write, combinational read (fetch sees old data)
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      for (int i = 0; i < MSG_MAX; i++) msg_buf[i] <= BLANK;
    end else if (wr_en) begin
      msg_buf[wr_addr] <= wr_data;
    end
  end

  // state and sequencing registers
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q <= ST_IDLE;
      pos_q   <= '0;
      len_q   <= '0;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      len_q   <= len_d;
      drain_q <= drain_d;
    end
  end

  // next state, fetch pointer and feed selection; start outranks any shift
  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    len_d   = len_q;
    drain_d = drain_q;
    shift   = 1'b0;
    clr     = 1'b0;
    feed    = BLANK;
    if (start) begin
      clr     = 1'b1;
      pos_d   = '0;
      drain_d = '0;
      len_d   = len_in;
      state_d = (len_in == '0) ? ST_DONE : ST_SCROLL;
    end else if (adv) begin
      unique case (state_q)
        ST_SCROLL: begin
          shift = 1'b1;
          feed  = msg_buf[pos_q];
          pos_d = pos_q + AW'(1);
          if ({1'b0, pos_q} == len_q - LEN_ONE) begin
            drain_d = '0;
            if (loop && GAP == 0) begin
              pos_d   = '0;
              state_d = ST_SCROLL;
            end else begin
              state_d = ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          shift   = 1'b1;
          feed    = BLANK;
          drain_d = drain_inc;
          if (loop && drain_inc >= GAP_N) begin
            pos_d   = '0;
            drain_d = '0;
            state_d = ST_SCROLL;
          end else if (!loop && drain_inc >= DRAIN_N) begin
            state_d = ST_DONE;
          end
        end
        default: ;
      endcase
    end
  end

  // display shift: entry digit takes the feed, the rest take their neighbour
  always_comb begin
    for (int k = 0; k < NUM_DIGITS; k++) disp_d[k] = disp_q[k];
    if (clr) begin
      for (int k = 0; k < NUM_DIGITS; k++) disp_d[k] = BLANK;
    end else if (shift) begin
      if (!dir) begin
        disp_d[0] = feed;
        for (int k = 1; k < NUM_DIGITS; k++) disp_d[k] = disp_q[k-1];
      end else begin
        for (int k = 0; k < NUM_DIGITS - 1; k++) disp_d[k] = disp_q[k+1];
        disp_d[NUM_DIGITS-1] = feed;
      end
    end
  end

  // display register
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      for (int k = 0; k < NUM_DIGITS; k++) disp_q[k] <= BLANK;
    end else begin
      for (int k = 0; k < NUM_DIGITS; k++) disp_q[k] <= disp_d[k];
    end
  end

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_hex
    assign hex[7*g +: 7] = disp_q[g];
  end

endmodule
